// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding and load/VDOT interlock for the 3-cycle execute pipeline
module hazard_fwd_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1Addr_ID,
    input  logic [4:0]  rs2Addr_ID,
    input  logic        rs1Used_ID,
    input  logic        rs2Used_ID,
    input  logic [31:0] rs1Data_RF,
    input  logic [31:0] rs2Data_RF,
    input  logic [4:0]  rdAddr_EXE_Hazard,
    input  logic        regWrite_EXE_Hazard,
    input  logic [2:0]  op_EXE_Hazard,
    input  logic [31:0] ALUOut_EXE_Hazard,
    input  logic [31:0] MemDataOut_EXE_Hazard,
    input  logic [31:0] VDOTOut_EXE_Hazard,
    output logic [31:0] rs1Data_fwd,
    output logic [31:0] rs2Data_fwd,
    output logic        stall_PC,
    output logic        stall_IF_ID,
    output logic        reg_DE_flush,
    output logic [31:0] stallCount
);
    typedef enum logic [1:0] {OP_ALU = 2'd0, OP_MEM = 2'd1, OP_VDOT = 2'd2} op_e;
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        op_e         op;
        logic [31:0] data;
    } slot_t;

    slot_t       slot0;
    slot_t       slot1;
    slot_t       slot2;
    logic [31:0] cnt_q;
    logic [32:0] res1;
    logic [32:0] res2;
    logic        stall;
    logic        unused_op_bit;

    assign unused_op_bit = op_EXE_Hazard[2];

    // Youngest matching slot wins; returns {not_ready, forwarded value}
    function automatic logic [32:0] pick(
        input logic        used,
        input logic [4:0]  rs,
        input logic [31:0] rf,
        input slot_t       s0,
        input slot_t       s1,
        input slot_t       s2,
        input logic [31:0] mem,
        input logic [31:0] vdot
    );
        logic hit;
        hit = used && rs != 5'd0;
        if (hit && s0.valid && s0.rd == rs)
            pick = {s0.op != OP_ALU, s0.data};
        else if (hit && s1.valid && s1.rd == rs)
            pick = {s1.op == OP_VDOT, s1.op == OP_MEM ? mem : s1.data};
        else if (hit && s2.valid && s2.rd == rs)
            pick = {1'b0, s2.op == OP_VDOT ? vdot : s2.data};
        else
            pick = {1'b0, rf};
    endfunction

    // Slot 0 is a view of the EXE taps; op encoding 3 folds into VDOT
    always_comb begin
        slot0.valid = regWrite_EXE_Hazard && rdAddr_EXE_Hazard != 5'd0;
        slot0.rd    = rdAddr_EXE_Hazard;
        slot0.op    = op_EXE_Hazard[1] ? OP_VDOT : op_e'(op_EXE_Hazard[1:0]);
        slot0.data  = ALUOut_EXE_Hazard;
    end

    // Resolve both sources independently, then merge into one interlock
    always_comb begin
        res1         = pick(rs1Used_ID, rs1Addr_ID, rs1Data_RF, slot0, slot1, slot2,
                            MemDataOut_EXE_Hazard, VDOTOut_EXE_Hazard);
        res2         = pick(rs2Used_ID, rs2Addr_ID, rs2Data_RF, slot0, slot1, slot2,
                            MemDataOut_EXE_Hazard, VDOTOut_EXE_Hazard);
        stall        = !rst && (res1[32] || res2[32]);
        rs1Data_fwd  = rst ? rs1Data_RF : res1[31:0];
        rs2Data_fwd  = rst ? rs2Data_RF : res2[31:0];
        stall_PC     = stall;
        stall_IF_ID  = stall;
        reg_DE_flush = stall;
        stallCount   = (cnt_q == 32'hFFFF_FFFF || !stall) ? cnt_q : cnt_q + 32'd1;
    end

    // Shift in-flight results down the pipeline; loads capture RAM data on leaving slot 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot1 <= '0;
            slot2 <= '0;
        end else begin
            slot2.valid <= slot1.valid;
            slot2.rd    <= slot1.rd;
            slot2.op    <= slot1.op;
            slot2.data  <= slot1.op == OP_MEM ? MemDataOut_EXE_Hazard : slot1.data;
            slot1.valid <= slot0.valid;
            slot1.rd    <= slot0.rd;
            slot1.op    <= slot0.op;
            slot1.data  <= slot0.op == OP_ALU ? slot0.data : 32'd0;
        end
    end

    // Stall counter holds the running total including the current cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 32'd0;
        else
            cnt_q <= stallCount;
    end
endmodule
